lfsr3_checker: RTL and testbench

LFSR3_CHECKER -- requirements
Module: lfsr3_checker

---
 rtl/lfsr3_checker.sv | 139 +++++++++++++
 tb/tb_lfsr3_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr3_checker.sv
// Checker for a 3-bit XNOR LFSR bit stream (taps 2 and 1).
// Acquires lock, then flywheels the sequence and counts bit errors.
module lfsr3_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       din,
    input  logic       din_valid,
    input  logic       clear_count,
    output logic       locked,
    output logic       bit_error,
    output logic [7:0] err_count
);

    localparam int unsigned SR_W   = 3;
    localparam int unsigned FILL_W = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 8;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(3);
    localparam logic [SR_W-1:0]   SR_LOCKUP = SR_W'(7);
    localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(255);
    localparam logic [CNT_W-1:0]  LOCK_CNT  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  LOSS_CNT  = CNT_W'(LOSS_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [SR_W-1:0]    sr, sr_nx;
    logic [FILL_W-1:0]  fill, fill_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               locked_nx;
    logic               bit_error_nx;
    logic [ERR_W-1:0]   err_count_nx;

    logic consume;
    logic pred;

    assign consume = enable & din_valid;
    assign pred    = ~(sr[2] ^ sr[1]);

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            cnt       <= '0;
            locked    <= 1'b0;
            bit_error <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            fill      <= fill_nx;
            cnt       <= cnt_nx;
            locked    <= locked_nx;
            bit_error <= bit_error_nx;
            err_count <= err_count_nx;
        end
    end

    // Next-state and next-output logic; cnt counts matches in CHECK, misses in LOCKED
    always_comb begin
        state_nx     = state;
        sr_nx        = sr;
        fill_nx      = fill;
        cnt_nx       = cnt;
        locked_nx    = locked;
        bit_error_nx = 1'b0;
        err_count_nx = err_count;

        if (consume) begin
            unique case (state)
                HUNT: begin
                    sr_nx   = {sr[1:0], din};
                    fill_nx = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
                    if (fill_nx == FILL_FULL && sr_nx != SR_LOCKUP) begin
                        state_nx = CHECK;
                        cnt_nx   = '0;
                    end
                end
                CHECK: begin
                    sr_nx = {sr[1:0], din};
                    if (din == pred) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt_nx == LOCK_CNT) begin
                            state_nx  = LOCKED;
                            cnt_nx    = '0;
                            locked_nx = 1'b1;
                        end
                    end else begin
                        state_nx = HUNT;
                        fill_nx  = '0;
                        cnt_nx   = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction, not the received bit, feeds the register
                    sr_nx = {sr[1:0], pred};
                    if (din != pred) begin
                        bit_error_nx = 1'b1;
                        if (err_count != ERR_MAX) begin
                            err_count_nx = err_count + ERR_W'(1);
                        end
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt_nx == LOSS_CNT) begin
                            state_nx  = HUNT;
                            fill_nx   = '0;
                            cnt_nx    = '0;
                            locked_nx = 1'b0;
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                default: begin
                    state_nx  = HUNT;
                    fill_nx   = '0;
                    cnt_nx    = '0;
                    locked_nx = 1'b0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment
        if (enable && clear_count) begin
            err_count_nx = '0;
        end
    end

endmodule

// File: tb/tb_lfsr3_checker.sv
// Randomised self-checking bench for lfsr3_checker against a behavioural model.
module tb_lfsr3_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clear_count = 1'b0;
    logic       locked;
    logic       bit_error;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr3_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .din         (din),
        .din_valid   (din_valid),
        .clear_count (clear_count),
        .locked      (locked),
        .bit_error   (bit_error),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    // Reference model: last three bits as a queue (oldest first), plus plain integer counters
    bit q[$];
    int m_mode;    // 0 searching, 1 verifying, 2 synchronised
    int m_fill;
    int m_run;
    int m_locked;
    int m_berr;
    int m_err;

    // Clean reference sequence of the XNOR LFSR
    bit pat[7];
    int pidx = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit v, input bit d, input bit clr);
        bit p;
        if (!rst) begin
            q = '{0, 0, 0};
            m_mode = 0; m_fill = 0; m_run = 0;
            m_locked = 0; m_berr = 0; m_err = 0;
            return;
        end
        m_berr = 0;
        if (!en) return;
        if (v) begin
            p = (q[0] == q[1]);
            if (m_mode == 0) begin
                q.push_back(d); void'(q.pop_front());
                m_fill = (m_fill < 3) ? m_fill + 1 : 3;
                if (m_fill == 3 && !(q[0] && q[1] && q[2])) begin
                    m_mode = 1; m_run = 0;
                end
            end else if (m_mode == 1) begin
                q.push_back(d); void'(q.pop_front());
                if (d == p) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_mode = 2; m_run = 0; m_locked = 1;
                    end
                end else begin
                    m_mode = 0; m_fill = 0; m_run = 0;
                end
            end else begin
                q.push_back(p); void'(q.pop_front());
                if (d != p) begin
                    m_berr = 1;
                    if (m_err < 255) m_err++;
                    m_run++;
                    if (m_run == LOSS_N) begin
                        m_mode = 0; m_fill = 0; m_run = 0; m_locked = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (clr) m_err = 0;
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge
    task automatic cycle(input bit rst, input bit en, input bit v, input bit d, input bit clr);
        @(negedge clock);
        reset = rst; enable = en; din_valid = v; din = d; clear_count = clr;
        model_step(rst, en, v, d, clr);
        @(posedge clock);
        #1;
        check("locked", int'(locked), m_locked);
        check("bit_error", int'(bit_error), m_berr);
        check("err_count", int'(err_count), m_err);
    endtask

    // Send the next reference bit, optionally flipped; the pattern advances only on consumed bits
    task automatic send(input bit en, input bit v, input bit flip, input bit clr);
        bit b;
        b = pat[pidx] ^ flip;
        if (en && v) pidx = (pidx + 1) % 7;
        cycle(1'b1, en, v, b, clr);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        pidx = 0;
    endtask

    initial begin
        pat = '{1, 1, 0, 1, 0, 0, 0};
        q = '{0, 0, 0};
        m_mode = 0; m_fill = 0; m_run = 0; m_locked = 0; m_berr = 0; m_err = 0;

        // Reset and acquisition
        do_reset();
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err_count), 0);
        for (int i = 0; i < 6; i++) send(1, 1, 0, 0);
        check("acq_not_yet", int'(locked), 0);
        send(1, 1, 0, 0);
        check("acq_lock7", int'(locked), 1);

        // Single error is flywheeled through
        send(1, 1, 1, 0);
        check("single_berr", int'(bit_error), 1);
        check("single_cnt", int'(err_count), 1);
        send(1, 1, 0, 0);
        check("single_pulse_end", int'(bit_error), 0);
        for (int i = 0; i < 10; i++) send(1, 1, 0, 0);
        check("single_still_locked", int'(locked), 1);

        // Loss after three consecutive errors, then relock
        for (int i = 0; i < 3; i++) send(1, 1, 1, 0);
        check("loss_unlocked", int'(locked), 0);
        check("loss_cnt", int'(err_count), 4);
        for (int i = 0; i < 7; i++) send(1, 1, 0, 0);
        check("relock", int'(locked), 1);

        // Lockup pattern never locks
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lockup_unlocked", int'(locked), 0);

        // Gapped clean stream: only consumed bits count
        do_reset();
        for (int i = 0; i < 40; i++)
            send(($urandom % 3) != 0, ($urandom % 3) != 0, 0, 0);

        // Saturation with alternating error/clean pairs
        do_reset();
        for (int i = 0; i < 7; i++) send(1, 1, 0, 0);
        for (int i = 0; i < 260; i++) begin
            send(1, 1, 1, 0);
            send(1, 1, 0, 0);
        end
        check("sat_255", int'(err_count), 255);
        check("sat_locked", int'(locked), 1);
        send(1, 1, 1, 1);
        check("clr_over_inc", int'(err_count), 0);
        check("clr_berr", int'(bit_error), 1);
        send(1, 1, 1, 0);
        send(0, 1, 0, 1);
        check("clr_ignored", int'(err_count), 1);
        check("en_low_berr", int'(bit_error), 0);

        // Reset mid-lock
        for (int i = 0; i < 5; i++) send(1, 1, 0, 0);
        do_reset();
        check("midlock_locked", int'(locked), 0);
        check("midlock_err", int'(err_count), 0);
        check("midlock_berr", int'(bit_error), 0);
        for (int i = 0; i < 7; i++) send(1, 1, 0, 0);
        check("midlock_relock", int'(locked), 1);

        // Random mix of gaps, errors, clears and resets
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 400) == 0) do_reset();
            else send(($urandom % 8) != 0, ($urandom % 4) != 0,
                      ($urandom % 12) == 0, ($urandom % 80) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
